// File: rtl/d_sc_serial_remainder_engine_if.sv
// Handshake and result bundle between the codeword source, the serial remainder
// engine (slave) and the downstream syndrome-evaluation stage.
interface d_sc_serial_remainder_engine_if #(
    parameter int REM_W = 168
);
    logic             i_cw_start;
    logic             i_cw_valid;
    logic             i_cw_bit;
    logic             o_cw_ready;
    logic             o_busy;
    logic             o_rem_valid;
    logic             i_rem_ack;
    logic [REM_W-1:0] o_remainders;
    logic             o_rem_zero;

    modport slave (
        input  i_cw_start, i_cw_valid, i_cw_bit, i_rem_ack,
        output o_cw_ready, o_busy, o_rem_valid, o_remainders, o_rem_zero
    );

    modport master (
        output i_cw_start, i_cw_valid, i_cw_bit, i_rem_ack,
        input  o_cw_ready, o_busy, o_rem_valid, o_remainders, o_rem_zero
    );
endinterface

// File: rtl/d_sc_serial_remainder_engine.sv
// Serial BCH remainder engine: 14 minimal-polynomial dividers (alpha^1..alpha^27, GF(2^12)).
// Optional registered all-zero flag enabled by defining D_SC_REM_ZERO_DETECT_EN.
module d_sc_min_poly_div_cell #(
    parameter logic [11:0] M_LOW = 12'h099
) (
    input  logic        i_message,
    input  logic [11:0] i_remainder,
    output logic [11:0] o_nxt_remainder
);
    assign o_nxt_remainder = {i_remainder[10:0], i_message}
                           ^ (i_remainder[11] ? M_LOW : 12'h000);
endmodule

module d_sc_serial_remainder_engine #(
    parameter int CW_LEN = 4095,
    parameter int CNT_W  = 12
) (
    input logic                           i_clk,
    input logic                           i_nRESET,
    d_sc_serial_remainder_engine_if.slave bus
);
    localparam int          GF_M      = 12;
    localparam int          NUM_CELLS = 14;
    localparam int          REM_W     = GF_M * NUM_CELLS;
    localparam logic [11:0] PRIM_LOW  = 12'h099;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CW_LEN - 1);

    function automatic logic [11:0] gf_mul(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        r = 12'h000;
        for (int i = GF_M - 1; i >= 0; i--) begin
            r = {r[10:0], 1'b0} ^ (r[11] ? PRIM_LOW : 12'h000);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Product of (x + beta^(2^k)) over the 12 conjugates of beta = alpha^idx. The monic
    // x^12 term never feeds the lower coefficients, so only the low 12 are tracked.
    function automatic logic [11:0] min_poly_low(input int idx);
        logic [11:0][11:0] poly;
        logic [11:0][11:0] nxt;
        logic [11:0]       conj;
        logic [11:0]       res;
        conj = 12'h001;
        for (int i = 0; i < idx; i++) conj = gf_mul(conj, 12'h002);
        poly    = '0;
        poly[0] = 12'h001;
        for (int k = 0; k < GF_M; k++) begin
            nxt[0] = gf_mul(conj, poly[0]);
            for (int j = 1; j < GF_M; j++) nxt[j] = poly[j-1] ^ gf_mul(conj, poly[j]);
            poly = nxt;
            conj = gf_mul(conj, conj);
        end
        for (int j = 0; j < GF_M; j++) res[j] = |poly[j];
        return res;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_nxt;
    logic             clear;
    logic             load;

    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
        d_sc_min_poly_div_cell #(
            .M_LOW(min_poly_low(2 * k + 1))
        ) u_cell (
            .i_message      (bus.i_cw_bit),
            .i_remainder    (rem_q[GF_M*k +: GF_M]),
            .o_nxt_remainder(rem_nxt[GF_M*k +: GF_M])
        );
    end

    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_cw_start) begin
                    clear   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.i_cw_valid) begin
                    load = 1'b1;
                    if (cnt_q == LAST_IDX) state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_rem_ack) begin
                    if (bus.i_cw_start) begin
                        clear   = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                cnt_q <= '0;
                rem_q <= '0;
            end else if (load) begin
                cnt_q <= cnt_q + 1'b1;
                rem_q <= rem_nxt;
            end
        end
    end

    // Handshake outputs come straight from the state register: no input-to-output path.
    assign bus.o_cw_ready   = (state_q == SHIFT);
    assign bus.o_rem_valid  = (state_q == HOLD);
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_remainders = rem_q;

`ifdef D_SC_REM_ZERO_DETECT_EN
    logic rem_zero_q;

    always_ff @(posedge i_clk) begin
        if (!i_nRESET) begin
            rem_zero_q <= 1'b0;
        end else if (clear) begin
            rem_zero_q <= 1'b0;
        end else if (load) begin
            rem_zero_q <= ~|rem_nxt;
        end
    end

    assign bus.o_rem_zero = rem_zero_q;
`else
    assign bus.o_rem_zero = 1'b0;
`endif
endmodule

// File: tb/tb_d_sc_serial_remainder_engine.sv
// Directed bench for d_sc_serial_remainder_engine; remainders are checked by evaluating
// them at alpha^i and comparing with the codeword syndrome computed in GF(2^12).
module tb_d_sc_serial_remainder_engine;
    localparam int CW_LEN    = 4095;
    localparam int GF_M      = 12;
    localparam int NUM_CELLS = 14;
    localparam int REM_W     = GF_M * NUM_CELLS;
`ifdef D_SC_REM_ZERO_DETECT_EN
    localparam logic ZERO_EN = 1'b1;
`else
    localparam logic ZERO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;
    logic cw [0:CW_LEN-1];

    always #5 clk = ~clk;

    d_sc_serial_remainder_engine_if #(.REM_W(REM_W)) bus ();

    d_sc_serial_remainder_engine #(
        .CW_LEN(CW_LEN),
        .CNT_W (12)
    ) dut (
        .i_clk   (clk),
        .i_nRESET(nreset),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [REM_W-1:0] obs, input logic [REM_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] gf_mul(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        r = 12'h000;
        for (int i = 11; i >= 0; i--) begin
            r = {r[10:0], 1'b0} ^ (r[11] ? 12'h099 : 12'h000);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [11:0] gf_pow(input int e);
        logic [11:0] r;
        r = 12'h001;
        for (int i = 0; i < e; i++) r = gf_mul(r, 12'h002);
        return r;
    endfunction

    // r(beta) must equal c(beta) for beta = alpha^(2k+1); this pins r down uniquely.
    task automatic verify_model(input string tag, input int nbits);
        for (int k = 0; k < NUM_CELLS; k++) begin
            logic [11:0] beta, syn, ev, slice;
            beta = gf_pow(2 * k + 1);
            syn  = 12'h000;
            for (int n = 0; n < nbits; n++) syn = gf_mul(syn, beta) ^ {11'b0, cw[n]};
            slice = bus.o_remainders[GF_M*k +: GF_M];
            ev    = 12'h000;
            for (int j = GF_M - 1; j >= 0; j--) ev = gf_mul(ev, beta) ^ {11'b0, slice[j]};
            check_eq($sformatf("%s_cell%0d", tag, 2 * k + 1), REM_W'(ev), REM_W'(syn));
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where o_rem_valid is seen.
    task automatic run_cw(input int bubble_pct, output int cycles, output int accepted);
        accepted = 0;
        cycles   = 0;
        bus.i_cw_start = 1'b1;
        bus.i_cw_valid = 1'b0;
        @(negedge clk);
        cycles++;
        bus.i_cw_start = 1'b0;
        while (!bus.o_rem_valid && cycles < 20000) begin
            if (accepted < CW_LEN && $urandom_range(99) >= bubble_pct) begin
                bus.i_cw_valid = 1'b1;
                bus.i_cw_bit   = cw[accepted];
                if (bus.o_cw_ready) accepted++;
            end else begin
                bus.i_cw_valid = 1'b0;
                bus.i_cw_bit   = 1'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        bus.i_cw_valid = 1'b0;
        check_eq("rem_valid_reached", REM_W'(bus.o_rem_valid), REM_W'(1));
    endtask

    task automatic ack_hold(input string tag);
        bus.i_rem_ack = 1'b1;
        @(negedge clk);
        bus.i_rem_ack = 1'b0;
        check_eq({tag, "_busy"}, REM_W'(bus.o_busy), REM_W'(0));
    endtask

    initial begin
        int cycles, acc, cyc;
        logic [REM_W-1:0] exp_v;

        bus.i_cw_start = 1'b0;
        bus.i_cw_valid = 1'b0;
        bus.i_cw_bit   = 1'b0;
        bus.i_rem_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", REM_W'(bus.o_cw_ready), REM_W'(0));
        check_eq("rst_valid", REM_W'(bus.o_rem_valid), REM_W'(0));
        check_eq("rst_busy", REM_W'(bus.o_busy), REM_W'(0));
        check_eq("rst_rem", bus.o_remainders, '0);
        check_eq("rst_zero", REM_W'(bus.o_rem_zero), REM_W'(0));
        nreset = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", REM_W'(bus.o_cw_ready), REM_W'(0));

        for (int n = 0; n < CW_LEN; n++) cw[n] = 1'b0;
        run_cw(0, cycles, acc);
        check_eq("zero_latency", REM_W'(cycles), REM_W'(CW_LEN + 1));
        check_eq("zero_count", REM_W'(acc), REM_W'(CW_LEN));
        check_eq("zero_rem", bus.o_remainders, '0);
        check_eq("zero_flag", REM_W'(bus.o_rem_zero), REM_W'(ZERO_EN));
        ack_hold("zero_ack");

        cw[CW_LEN-1] = 1'b1;
        exp_v = {NUM_CELLS{12'h001}};
        run_cw(0, cycles, acc);
        check_eq("last_rem", bus.o_remainders, exp_v);
        check_eq("last_flag", REM_W'(bus.o_rem_zero), REM_W'(0));
        ack_hold("last_ack");
        check_eq("idle_keeps_rem", bus.o_remainders, exp_v);

        cw[CW_LEN-1]  = 1'b0;
        cw[CW_LEN-13] = 1'b1;
        run_cw(0, cycles, acc);
        check_eq("x12_slice0", REM_W'(bus.o_remainders[11:0]), REM_W'(12'h099));
        verify_model("x12", CW_LEN);
        bus.i_cw_start = 1'b1;
        repeat (3) @(negedge clk);
        bus.i_cw_start = 1'b0;
        check_eq("hold_start_valid", REM_W'(bus.o_rem_valid), REM_W'(1));
        check_eq("hold_start_ready", REM_W'(bus.o_cw_ready), REM_W'(0));
        check_eq("hold_start_slice0", REM_W'(bus.o_remainders[11:0]), REM_W'(12'h099));
        ack_hold("x12_ack");
        check_eq("idle_keeps_x12", REM_W'(bus.o_remainders[11:0]), REM_W'(12'h099));

        for (int n = 0; n < CW_LEN; n++) cw[n] = 1'($urandom);
        run_cw(30, cycles, acc);
        check_eq("rand_count", REM_W'(acc), REM_W'(CW_LEN));
        verify_model("rand", CW_LEN);

        bus.i_rem_ack  = 1'b1;
        bus.i_cw_start = 1'b1;
        @(negedge clk);
        bus.i_rem_ack  = 1'b0;
        check_eq("b2b_ready", REM_W'(bus.o_cw_ready), REM_W'(1));
        check_eq("b2b_valid", REM_W'(bus.o_rem_valid), REM_W'(0));
        check_eq("b2b_rem", bus.o_remainders, '0);
        check_eq("b2b_zero", REM_W'(bus.o_rem_zero), REM_W'(0));

        // Feed 100 bits with start held high; it must not restart the codeword.
        for (int n = 0; n < CW_LEN; n++) cw[n] = 1'($urandom);
        acc = 0;
        cyc = 0;
        while (acc < 100 && cyc < 1000) begin
            bus.i_cw_valid = 1'b1;
            bus.i_cw_bit   = cw[acc];
            if (bus.o_cw_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        bus.i_cw_valid = 1'b0;
        bus.i_cw_start = 1'b0;
        check_eq("partial_count", REM_W'(acc), REM_W'(100));
        check_eq("partial_ready", REM_W'(bus.o_cw_ready), REM_W'(1));
        verify_model("partial", 100);

        nreset = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", REM_W'(bus.o_cw_ready), REM_W'(0));
        check_eq("abort_valid", REM_W'(bus.o_rem_valid), REM_W'(0));
        check_eq("abort_busy", REM_W'(bus.o_busy), REM_W'(0));
        check_eq("abort_rem", bus.o_remainders, '0);
        check_eq("abort_zero", REM_W'(bus.o_rem_zero), REM_W'(0));
        nreset = 1'b1;
        @(negedge clk);

        for (int n = 0; n < CW_LEN; n++) cw[n] = 1'($urandom);
        run_cw(0, cycles, acc);
        check_eq("post_rst_latency", REM_W'(cycles), REM_W'(CW_LEN + 1));
        verify_model("post_rst", CW_LEN);
        ack_hold("post_rst_ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
